// File: rtl/delay_pipe_stage.sv
// One pipeline slot: a valid bit plus WIDTH data bits that advance when the
// downstream chain makes room; data only captures on a valid incoming beat.
module delay_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= prev_vld;
      // empty slots keep stale data to avoid needless toggling
      if (prev_vld) dat <= prev_dat;
    end
  end

endmodule

// File: rtl/delay_pipe.sv
// Elastic DEPTH-stage delay line with valid/ready on both sides, bubble
// collapse under backpressure, synchronous flush and a live occupancy count.
module delay_pipe #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic                        in_xfer;
  logic                        out_xfer;

  // Ready ripples back from the output; any empty slot lets everything behind it move.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~vld[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--)
      adv[k] = adv[k+1] | ~vld[k];
  end

  assign in_ready  = adv[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (k == 0) begin : g_head
      assign pv = in_xfer;
      assign pd = in_data;
    end else begin : g_body
      assign pv = vld[k-1];
      assign pd = dat[k-1];
    end
    delay_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .adv      (adv[k]),
      .prev_vld (pv),
      .prev_dat (pd),
      .vld      (vld[k]),
      .dat      (dat[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occupancy <= '0;
    else if (flush)
      occupancy <= '0;
    else
      occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Bench for delay_pipe: directed table, hand sequences and random traffic
// checked against a queue-of-beats reference model.
module tb_delay_pipe;
  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] occupancy;

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: each in-flight beat remembers which slot it sits in (DEPTH-1 = output).
  typedef struct { logic [WIDTH-1:0] d; int p; } beat_t;
  beat_t q[$];

  logic             s_ir, s_ov;
  logic [WIDTH-1:0] s_od;
  logic [CNT_W-1:0] s_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ov();
    return q.size() > 0 && q[0].p == DEPTH - 1;
  endfunction

  function automatic logic m_ir(input logic ordy, input logic fl);
    return !fl && (q.size() < DEPTH || ordy);
  endfunction

  task automatic m_update(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
    logic ov, ir;
    int   lim, np;
    ov = m_ov();
    ir = m_ir(ordy, fl);
    if (ov && ordy) void'(q.pop_front());
    if (fl) q.delete();
    else begin
      lim = DEPTH - 1;
      for (int i = 0; i < q.size(); i++) begin
        np = (q[i].p + 1 < lim) ? q[i].p + 1 : lim;
        q[i].p = np;
        lim = np - 1;
      end
      if (iv && ir) q.push_back('{d: id, p: 0});
    end
  endtask

  // One clock: drive after negedge, sample and check mid-low-phase, model steps at posedge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_occ = occupancy;
    chk("in_ready", 32'(s_ir), 32'(m_ir(ordy, fl)));
    chk("out_valid", 32'(s_ov), 32'(m_ov()));
    if (m_ov()) chk("out_data", s_od, q[0].d);
    chk("occupancy", 32'(s_occ), 32'(q.size()));
    @(posedge clk);
    m_update(iv, id, ordy, fl);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic iv; logic [WIDTH-1:0] id; logic ordy; logic fl;
    logic e_ir; logic e_ov; logic [CNT_W-1:0] e_occ; logic [WIDTH-1:0] e_od;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int first_ov, nout;
    logic ov_seen;

    // Full-stall table: 12 beats offered with out_ready low.
    tbl[0]  = '{1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0};
    tbl[1]  = '{1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  32'h0};
    tbl[2]  = '{1'b1, 32'h103, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2,  32'h0};
    tbl[3]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  32'h0};
    tbl[4]  = '{1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4,  32'h0};
    tbl[5]  = '{1'b1, 32'h106, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  32'h0};
    tbl[6]  = '{1'b1, 32'h107, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6,  32'h0};
    tbl[7]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7,  32'h0};
    tbl[8]  = '{1'b1, 32'h109, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8,  32'h0};
    tbl[9]  = '{1'b1, 32'h10A, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9,  32'h0};
    tbl[10] = '{1'b1, 32'h10B, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 32'h101};
    tbl[11] = '{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 32'h101};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Stream 20 beats with out_ready high; latency and ordering.
    first_ov = -1; nout = 0;
    for (int i = 0; i < 34; i++) begin
      step(i < 20, 32'(i + 1), 1'b1, 1'b0);
      if (s_ov && first_ov < 0) first_ov = i;
      if (s_ov) begin
        nout++;
        chk("stream_order", s_od, 32'(nout));
      end
      if (i == 15) chk("stream_occ_mid", 32'(s_occ), 32'(DEPTH));
    end
    chk("stream_latency", 32'(first_ov), 32'(DEPTH));
    chk("stream_count", 32'(nout), 32'd20);
    chk("stream_occ_end", 32'(occupancy), 32'd0);

    // Full stall via table, then release and drain.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      chk("tbl_in_ready", 32'(s_ir), 32'(tbl[i].e_ir));
      chk("tbl_out_valid", 32'(s_ov), 32'(tbl[i].e_ov));
      chk("tbl_occ", 32'(s_occ), 32'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk("tbl_out_data", s_od, tbl[i].e_od);
    end
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 2, 32'h10B + 32'(i), 1'b1, 1'b0);
      if (s_ov) begin
        chk("stall_order", s_od, 32'h101 + 32'(nout));
        nout++;
      end
    end
    chk("stall_count", 32'(nout), 32'd12);

    // Bubble collapse: A, 3 idle, B, stalled output.
    step(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB0002, 1'b0, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bub_a_valid", 32'(s_ov), 32'd1);
    chk("bub_a_data", s_od, 32'hAAAA0001);
    chk("bub_occ", 32'(s_occ), 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bub_b_valid", 32'(s_ov), 32'd1);
    chk("bub_b_data", s_od, 32'hBBBB0002);
    drain();

    // Full with simultaneous in/out.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
      chk("full_in_ready", 32'(s_ir), 32'd1);
      chk("full_occ", 32'(s_occ), 32'(DEPTH));
    end
    drain();

    // Flush with 6 beats in flight.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'h4FF, 1'b1, 1'b1);
    chk("flush_in_ready", 32'(s_ir), 32'd0);
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(s_ov), 32'd0);
    chk("flush_occ", 32'(s_occ), 32'd0);
    ov_seen = 1'b0; first_ov = -1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_ov) begin
        chk("flush_new_data", s_od, 32'hCAFEF00D);
        if (!ov_seen) first_ov = i;
        ov_seen = 1'b1;
      end
    end
    chk("flush_new_latency", 32'(first_ov), 32'(DEPTH - 1));

    // Async reset between edges mid-stream.
    for (int i = 0; i < 12; i++) step(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("arst_no_stale", 32'(s_ov), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 50) == 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
